dffnq_serial_deser: RTL and testbench
=====================================

// Module: dffnq_serial_deser
// PURPOSE
//  Serial-to-parallel deserializer placed directly downstream of the negative-edge D flip-flop.
//  - Consumes the retimed serial bit stream that flop produces.
//  - Assembles WIDTH-bit words and presents them on a valid/ready output port.
//  - Runs on the same falling edge, so there is no half-cycle path between the flop and this block.
//  - Flags words that are lost because the consumer stalled.
// PARAMETERS
//  WIDTH     8   bits per word; legal range 2..32
//  MSB_FIRST 0   0: first received bit lands in Q[0]; 1: first received bit lands in Q[WIDTH-1]
// PORTS
//  CLKN     input   1      clock; every state element updates on the falling edge of CLKN
//  RST      input   1      reset: synchronous, active-high, sampled on falling CLKN; one clock only
//  D        input   1      serial data bit, from the upstream flop output
//  D_EN     input   1      1: D is a valid bit this cycle; 0: hold, nothing is shifted
//  FRAME    input   1      1 together with D_EN: this bit is bit 0 of a new word (resynchronise)
//  Q        output  WIDTH  assembled word; valid while Q_VALID=1
//  Q_VALID  output  1      output holding register full
//  Q_READY  input   1      consumer accepts Q on a falling edge where Q_VALID & Q_READY
//  OVF      output  1      sticky flag: at least one completed word was dropped
//  OVF_CLR  input   1      clears OVF on the next falling edge
// BEHAVIOUR
//  Reset values, applied on the first falling edge with RST=1:
//   shift reg=0, bit count=0, Q=0, Q_VALID=0, OVF=0. RST overrides all other inputs.
//  Reset mid-word discards the partial word. Reset while Q_VALID=1 drops the held word and does not set OVF.
//  Bit path, on each edge with D_EN=1:
//   - D shifts into the shift register in the position set by MSB_FIRST.
//   - Bit count increments.
//   - FRAME=1 forces this bit to be bit 0: the partial word is discarded and count becomes 1.
//   - D_EN=0: shift register and count hold, even if FRAME=1.
//  Word completion: the edge at which the WIDTH-th bit is shifted in.
//   - The completed word, including that bit, is transferred to the holding register if either:
//     Q_VALID=0, or Q_VALID=1 and Q_READY=1 on the same edge (simultaneous accept and refill).
//     After transfer Q_VALID stays 1 and count returns to 0.
//   - Otherwise the new word is dropped, Q and Q_VALID are unchanged, OVF<=1, and count returns to 0.
//  Latency: Q_VALID rises on the falling edge that samples the last bit, i.e. 0 extra edges.
//   Q is registered and is stable for a full CLKN period.
//  Handshake:
//   - Accept with no completion that edge: Q_VALID<=0; Q holds its last value and may not be relied on.
//   - Q_READY while Q_VALID=0 is ignored.
//   - Q must not change while Q_VALID=1 and no accept has occurred.
//  OVF:
//   - OVF_CLR=1 clears OVF. If a drop happens on the same edge, set wins (OVF stays 1).
//   - OVF is never cleared by an accept.
//  Bit count wraps WIDTH-1 -> 0 only at word completion. Its width is $clog2(WIDTH+1).
//  No X propagation requirements beyond plain RTL. No combinational path from D or D_EN to any output.
// STRUCTURE
//  Shared package dffnq_deser_pkg:
//   - WIDTH range checks (elaboration error outside 2..32).
//   - CNT_W = $clog2(WIDTH+1).
//   - Encodings of the two holding states: EMPTY, FULL.
//  Holding register: two-state FSM, EMPTY <-> FULL. The transitions are exactly the rules above.
//  One natural sub-module: dffnq_deser_shift.
//   - Contains the shift register and bit counter, with FRAME and D_EN handling.
//   - Outputs a one-cycle 'word_done' pulse and the parallel word.
//   - The top level owns the holding register, the FSM and OVF.
// TESTING
//  1. RST=1 for 2 edges, then D_EN=1 with D=1,0,1,1,0,0,1,0 (WIDTH=8, MSB_FIRST=0), Q_READY=1
//     -> Q=8'h4D, Q_VALID=1 on the 8th edge, cleared the next edge; OVF=0.
//  2. Same stream with Q_READY=0, then a second word 8'hFF
//     -> Q stays 8'h4D, Q_VALID stays 1, OVF=1 on the 16th edge; OVF_CLR=1 -> OVF=0.
//  3. Q_READY=1 exactly on the completion edge of the 2nd word (8'h4D then 8'hA5)
//     -> Q becomes 8'hA5, Q_VALID stays 1, OVF=0.
//  4. Three bits shifted, then FRAME=1 with D_EN=1, then 7 more bits
//     -> word assembled from the FRAME bit onward, and completion at the 8th bit counted from FRAME.
//  5. D_EN toggles 0/1 every edge through a full word
//     -> Q identical to the contiguous case; completion after 8 enabled edges.
//  6. RST asserted at bit 5 and while Q_VALID=1 -> all outputs 0 on that edge; the next word assembles cleanly.

Source files
------------

// File: rtl/dffnq_deser_pkg.sv
// Shared definitions for the falling-edge serial deserializer: width limits,
// bit-counter sizing and the holding-register state encoding.
package dffnq_deser_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/dffnq_deser_shift.sv
// Shift register and bit counter; word/word_done are the combinational
// next-state view so the top can capture a word on the edge its last bit arrives.
module dffnq_deser_shift
  import dffnq_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clkn,
  input  logic             rst,
  input  logic             d,
  input  logic             d_en,
  input  logic             frame,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] base;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  // FRAME restarts the word: the incoming bit is shifted into an empty register.
  always_comb begin
    base      = frame ? '0 : sreg;
    cnt_base  = frame ? '0 : cnt;
    word      = MSB_FIRST ? {base[WIDTH-2:0], d} : {d, base[WIDTH-1:1]};
    cnt_nxt   = cnt_base + CNT_W'(1);
    word_done = d_en && (cnt_nxt == CNT_W'(WIDTH));
  end

  always_ff @(negedge clkn) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (d_en) begin
      sreg <= word;
      cnt  <= word_done ? '0 : cnt_nxt;
    end
  end

endmodule

// File: rtl/dffnq_serial_deser.sv
// Falling-edge serial-to-parallel deserializer with a one-word valid/ready
// holding register and a sticky overflow flag for words dropped on a stall.
module dffnq_serial_deser
  import dffnq_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLKN,
  input  logic             RST,
  input  logic             D,
  input  logic             D_EN,
  input  logic             FRAME,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             OVF,
  input  logic             OVF_CLR
);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("dffnq_serial_deser: WIDTH must be within 2..32");
  end

  hold_state_t      state;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             drop;

  dffnq_deser_shift #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clkn     (CLKN),
    .rst      (RST),
    .d        (D),
    .d_en     (D_EN),
    .frame    (FRAME),
    .word_done(word_done),
    .word     (word)
  );

  // A completed word fits if the holder is empty or is being drained this edge.
  always_comb begin
    load = word_done && ((state == EMPTY) || Q_READY);
    drop = word_done && (state == FULL) && !Q_READY;
  end

  always_ff @(negedge CLKN) begin
    if (RST) begin
      state <= EMPTY;
      Q     <= '0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            Q     <= word;
            state <= FULL;
          end
        end
        FULL: begin
          if (load) begin
            Q <= word;
          end else if (Q_READY) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      // Set takes priority over clear.
      OVF <= drop | (OVF & ~OVF_CLR);
    end
  end

  assign Q_VALID = (state == FULL);

endmodule

// File: tb/tb_dffnq_serial_deser.sv
// Bench: directed vector table plus randomized traffic against a bit-queue model,
// on a WIDTH=8 LSB-first instance and a WIDTH=5 MSB-first instance.
module tb_dffnq_serial_deser;

  logic       CLKN;
  logic       RST, D, D_EN, FRAME, Q_READY, OVF_CLR;
  logic [7:0] qa;
  logic       qa_vld, ovfa;
  logic [4:0] qb;
  logic       qb_vld, ovfb;

  int tests = 0;
  int fails = 0;
  int step  = 0;

  dffnq_serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
    .CLKN(CLKN), .RST(RST), .D(D), .D_EN(D_EN), .FRAME(FRAME),
    .Q(qa), .Q_VALID(qa_vld), .Q_READY(Q_READY), .OVF(ovfa), .OVF_CLR(OVF_CLR)
  );

  dffnq_serial_deser #(.WIDTH(5), .MSB_FIRST(1'b1)) dut_b (
    .CLKN(CLKN), .RST(RST), .D(D), .D_EN(D_EN), .FRAME(FRAME),
    .Q(qb), .Q_VALID(qb_vld), .Q_READY(Q_READY), .OVF(ovfb), .OVF_CLR(OVF_CLR)
  );

  initial CLKN = 1'b1;
  always #5 CLKN = ~CLKN;

  typedef struct packed {
    logic [31:0] bits;   // bits[i] = i-th bit received in the current word
    logic [31:0] q;
    logic [5:0]  n;
    logic        vld;
    logic        ovf;
  } mst_t;

  typedef struct packed {
    logic       rst, d, den, frame, rdy, clr;
    logic       ev, eo;
    logic [7:0] eq;
    logic       cq;
  } vec_t;

  vec_t vecs[$];
  mst_t ma, mb;

  function automatic mst_t mstep(mst_t s, int w, bit msbf,
                                 bit rst, bit d, bit den, bit frame, bit rdy, bit clr);
    mst_t r;
    logic [31:0] word;
    bit done;
    bit drop;
    r = s; word = '0; done = 0; drop = 0;
    if (rst) begin
      r = '0;
      return r;
    end
    if (den) begin
      if (frame) begin
        r.bits = '0;
        r.n    = '0;
      end
      r.bits[r.n] = d;
      r.n = r.n + 6'd1;
      if (int'(r.n) == w) begin
        done = 1;
        for (int i = 0; i < w; i++) word[msbf ? (w - 1 - i) : i] = r.bits[i];
        r.n = '0;
        r.bits = '0;
      end
    end
    if (done) begin
      if (!s.vld || rdy) begin
        r.q   = word;
        r.vld = 1'b1;
      end else begin
        drop = 1;
      end
    end else if (s.vld && rdy) begin
      r.vld = 1'b0;
    end
    r.ovf = drop ? 1'b1 : (clr ? 1'b0 : s.ovf);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", nm, step, act, exp);
    end
  endtask

  task automatic v(input bit rst, input bit d, input bit den, input bit frame,
                   input bit rdy, input bit clr, input bit ev, input bit eo,
                   input logic [7:0] eq, input bit cq);
    vec_t t;
    t.rst = rst; t.d = d; t.den = den; t.frame = frame; t.rdy = rdy; t.clr = clr;
    t.ev = ev; t.eo = eo; t.eq = eq; t.cq = cq;
    vecs.push_back(t);
  endtask

  // Bits 0..6 of w, LSB first; outputs expected to hold steady throughout.
  task automatic bits7(input logic [7:0] w, input bit rdy, input bit ev, input bit eo,
                       input logic [7:0] eq);
    for (int i = 0; i < 7; i++) v(0, w[i], 1, 0, rdy, 0, ev, eo, eq, ev);
  endtask

  task automatic apply(input bit rst, input bit d, input bit den, input bit frame,
                       input bit rdy, input bit clr);
    RST = rst; D = d; D_EN = den; FRAME = frame; Q_READY = rdy; OVF_CLR = clr;
    @(negedge CLKN);
    ma = mstep(ma, 8, 1'b0, rst, d, den, frame, rdy, clr);
    mb = mstep(mb, 5, 1'b1, rst, d, den, frame, rdy, clr);
    #1;
    step++;
  endtask

  task automatic chk_b();
    chk("b_vld", {31'b0, qb_vld}, {31'b0, mb.vld});
    chk("b_ovf", {31'b0, ovfb}, {31'b0, mb.ovf});
    if (mb.vld) chk("b_q", {27'b0, qb}, {27'b0, mb.q[4:0]});
  endtask

  initial begin
    logic [7:0] w;
    RST = 0; D = 0; D_EN = 0; FRAME = 0; Q_READY = 0; OVF_CLR = 0;
    ma = '0; mb = '0;

    // reset, two edges
    v(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    v(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    // contiguous word, consumer ready
    bits7(8'h4D, 1, 0, 0, 8'h00);
    v(0, 0, 1, 0, 1, 0, 1, 0, 8'h4D, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    // stall: second word dropped, OVF set; drop+clear keeps OVF; clear, then accept
    bits7(8'h4D, 0, 0, 0, 8'h00);
    v(0, 0, 1, 0, 0, 0, 1, 0, 8'h4D, 1);
    bits7(8'hFF, 0, 1, 0, 8'h4D);
    v(0, 1, 1, 0, 0, 0, 1, 1, 8'h4D, 1);
    bits7(8'hFF, 0, 1, 1, 8'h4D);
    v(0, 1, 1, 0, 0, 1, 1, 1, 8'h4D, 1);
    v(0, 0, 0, 0, 0, 1, 1, 0, 8'h4D, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    // accept and refill on the same edge
    bits7(8'h4D, 0, 0, 0, 8'h00);
    v(0, 0, 1, 0, 0, 0, 1, 0, 8'h4D, 1);
    bits7(8'hA5, 0, 1, 0, 8'h4D);
    v(0, 1, 1, 0, 1, 0, 1, 0, 8'hA5, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    // three stray bits, then FRAME resynchronises
    for (int i = 0; i < 3; i++) v(0, 1, 1, 0, 1, 0, 0, 0, 8'h00, 0);
    w = 8'h4D;
    v(0, w[0], 1, 1, 1, 0, 0, 0, 8'h00, 0);
    for (int i = 1; i < 7; i++) v(0, w[i], 1, 0, 1, 0, 0, 0, 8'h00, 0);
    v(0, w[7], 1, 0, 1, 0, 1, 0, 8'h4D, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    // D_EN toggling; FRAME on idle edges must be ignored
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      v(0, ~w[i], 0, 1, 1, 0, 0, 0, 8'h00, 0);
      v(0, w[i], 1, 0, 1, 0, i == 7, 0, (i == 7) ? 8'hA5 : 8'h00, i == 7);
    end
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    // reset mid-word, clean word after, reset while holding, clean word after
    for (int i = 0; i < 5; i++) v(0, 1, 1, 0, 1, 0, 0, 0, 8'h00, 0);
    v(1, 1, 1, 1, 1, 1, 0, 0, 8'h00, 1);
    bits7(8'h4D, 1, 0, 0, 8'h00);
    v(0, 0, 1, 0, 0, 0, 1, 0, 8'h4D, 1);
    v(0, 0, 0, 0, 0, 0, 1, 0, 8'h4D, 1);
    v(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    bits7(8'hA5, 1, 0, 0, 8'h00);
    v(0, 1, 1, 0, 1, 0, 1, 0, 8'hA5, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      apply(vecs[k].rst, vecs[k].d, vecs[k].den, vecs[k].frame, vecs[k].rdy, vecs[k].clr);
      chk("a_vld", {31'b0, qa_vld}, {31'b0, vecs[k].ev});
      chk("a_ovf", {31'b0, ovfa}, {31'b0, vecs[k].eo});
      if (vecs[k].cq) chk("a_q", {24'b0, qa}, {24'b0, vecs[k].eq});
      chk_b();
    end

    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);
      chk("ra_vld", {31'b0, qa_vld}, {31'b0, ma.vld});
      chk("ra_ovf", {31'b0, ovfa}, {31'b0, ma.ovf});
      if (ma.vld) chk("ra_q", {24'b0, qa}, {24'b0, ma.q[7:0]});
      chk_b();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
